sdram_read_exec: RTL and testbench



---
 rtl/sdram_pkg.sv | 32 +++
 rtl/sdram_ref_timer.sv | 43 ++++
 rtl/sdram_read_exec.sv | 180 ++++++++++++++++++
 tb/tb_sdram_read_exec.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Constants and state encodings shared by the SDRAM read, write and init engines.
package sdram_pkg;

    // {cs, ras, cas, we}
    localparam logic [3:0] NOP_CD    = 4'b0111;
    localparam logic [3:0] ACTIVE_CD = 4'b0011;
    localparam logic [3:0] READ_CD   = 4'b0101;
    localparam logic [3:0] CHARGE_CD = 4'b0010;
    localparam logic [3:0] REF_CD    = 4'b0001;

    localparam int TIME_TRP  = 3;
    localparam int TIME_TRC  = 7;
    localparam int TIME_TRCD = 3;
    localparam int TIME_REF  = 1562;
    localparam int CAS_LAT   = 3;
    localparam int BURST_LEN = 256;

    localparam int WAIT_W = 9;
    localparam int REF_W  = 11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REF  = 3'd1;
    localparam logic [2:0] ST_ACT  = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_PRE  = 3'd4;

    // Wait counters count down to zero, so a state lasting N cycles loads N-1.
    function automatic logic [WAIT_W-1:0] wait_cnt(input int cycles);
        return WAIT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: reload down-counter plus a sticky pending flag.
module sdram_ref_timer import sdram_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic ref_issued,
    output logic ref_pending
);

    localparam logic [REF_W-1:0] RELOAD = REF_W'(TIME_REF - 1);

    logic [REF_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (!enable) begin
            cnt_d  = RELOAD;
            pend_d = 1'b0;
        end else if (cnt_q == '0) begin
            // Expiry wins over a simultaneous issue so no interval is lost.
            cnt_d  = RELOAD;
            pend_d = 1'b1;
        end else begin
            cnt_d  = cnt_q - 1'b1;
            pend_d = pend_q & ~ref_issued;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= RELOAD;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign ref_pending = pend_q;

endmodule

// File: rtl/sdram_read_exec.sv
// SDRAM read-side engine: auto-refresh plus ACTIVE / full-page READ / PRECHARGE,
// with a CL-aligned capture window producing a 256-word read stream.
module sdram_read_exec import sdram_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int IADD_W = 22,
    parameter int OADD_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              rd_req,
    input  logic [IADD_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              busy,
    output logic              cke,
    output logic              cs,
    output logic              ras,
    output logic              cas,
    output logic              we,
    output logic [1:0]        dqm,
    output logic [OADD_W-1:0] addr,
    output logic [1:0]        bank,
    input  logic [DATA_W-1:0] dq_in
);

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        lat_bank_q, lat_bank_d;
    logic [7:0]        lat_col_q, lat_col_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [OADD_W-1:0] addr_q, addr_d;
    logic [1:0]        bank_q, bank_d;
    logic [1:0]        dqm_q, dqm_d;
    logic              cke_q, cke_d;
    logic              rd_ack_q, rd_ack_d;
    logic              ref_pending, ref_issued;

    logic [CAS_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [8:0]         word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_data_vld_q, rd_data_vld_d;
    logic               dq_window;

    sdram_ref_timer u_ref_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (init_done),
        .ref_issued  (ref_issued),
        .ref_pending (ref_pending)
    );

    // Commands are decided on the transition and registered, so each lands on
    // the pins in the first cycle of the state it opens.
    always_comb begin
        // NOTE: every signal gets a default before the case; a path that skips
        // an assignment would otherwise infer a latch.
        state_d    = state_q;
        wait_d     = wait_q;
        lat_bank_d = lat_bank_q;
        lat_col_d  = lat_col_q;
        cmd_d      = NOP_CD;
        addr_d     = '0;
        bank_d     = '0;
        rd_ack_d   = 1'b0;
        ref_issued = 1'b0;
        dqm_d      = init_done ? 2'b00 : 2'b11;
        cke_d      = 1'b1;
        if (!init_done) begin
            state_d = ST_IDLE;
            wait_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ref_pending) begin
                        state_d    = ST_REF;
                        wait_d     = wait_cnt(TIME_TRC);
                        cmd_d      = REF_CD;
                        ref_issued = 1'b1;
                    end else if (rd_req) begin
                        state_d    = ST_ACT;
                        wait_d     = wait_cnt(TIME_TRCD);
                        cmd_d      = ACTIVE_CD;
                        bank_d     = rd_addr[21:20];
                        addr_d     = OADD_W'(rd_addr[19:8]);
                        lat_bank_d = rd_addr[21:20];
                        lat_col_d  = rd_addr[7:0];
                        rd_ack_d   = 1'b1;
                    end
                end
                ST_ACT: begin
                    if (wait_q == '0) begin
                        state_d = ST_RD;
                        wait_d  = wait_cnt(BURST_LEN);
                        cmd_d   = READ_CD;
                        bank_d  = lat_bank_q;
                        addr_d  = OADD_W'(lat_col_q);
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
                ST_RD: begin
                    if (wait_q == '0) begin
                        state_d    = ST_PRE;
                        wait_d     = wait_cnt(TIME_TRP);
                        cmd_d      = CHARGE_CD;
                        addr_d[10] = 1'b1;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
                ST_REF, ST_PRE: begin
                    if (wait_q == '0) state_d = ST_IDLE;
                    else              wait_d  = wait_q - 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The READ on the pins arms the shift register; its tail marks the first
    // word on dq, and the counter holds the window open for the remaining 255.
    always_comb begin
        vld_sr_d      = {vld_sr_q[CAS_LAT-2:0], cmd_q == READ_CD};
        dq_window     = vld_sr_q[CAS_LAT-1] | (word_cnt_q != '0);
        word_cnt_d    = '0;
        if (vld_sr_q[CAS_LAT-1])    word_cnt_d = 9'(BURST_LEN - 1);
        else if (word_cnt_q != '0)  word_cnt_d = word_cnt_q - 1'b1;
        rd_data_vld_d = dq_window;
        rd_data_d     = dq_in;
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            lat_bank_q    <= '0;
            lat_col_q     <= '0;
            cmd_q         <= NOP_CD;
            addr_q        <= '0;
            bank_q        <= '0;
            dqm_q         <= 2'b11;
            cke_q         <= 1'b1;
            rd_ack_q      <= 1'b0;
            vld_sr_q      <= '0;
            word_cnt_q    <= '0;
            rd_data_q     <= '0;
            rd_data_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            lat_bank_q    <= lat_bank_d;
            lat_col_q     <= lat_col_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            bank_q        <= bank_d;
            dqm_q         <= dqm_d;
            cke_q         <= cke_d;
            rd_ack_q      <= rd_ack_d;
            vld_sr_q      <= vld_sr_d;
            word_cnt_q    <= word_cnt_d;
            rd_data_q     <= rd_data_d;
            rd_data_vld_q <= rd_data_vld_d;
        end
    end

    assign {cs, ras, cas, we} = cmd_q;
    assign addr        = addr_q;
    assign bank        = bank_q;
    assign dqm         = dqm_q;
    assign cke         = cke_q;
    assign rd_ack      = rd_ack_q;
    assign rd_data     = rd_data_q;
    assign rd_data_vld = rd_data_vld_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_read_exec.sv
// Directed bench for sdram_read_exec: command timing, refresh cadence and
// priority, full-page capture with column wrap, and reset mid-burst.
module tb_sdram_read_exec;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        rst, init_done, rd_req;
    logic [21:0] rd_addr;
    logic [15:0] dq_in;
    logic        rd_ack, rd_data_vld, busy, cke, cs, ras, cas, we;
    logic [15:0] rd_data;
    logic [1:0]  dqm, bank;
    logic [11:0] addr;
    logic [3:0]  cmd;

    always #5 clk = ~clk;

    sdram_read_exec dut (
        .clk(clk), .rst(rst), .init_done(init_done), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_data_vld(rd_data_vld), .busy(busy),
        .cke(cke), .cs(cs), .ras(ras), .cas(cas), .we(we), .dqm(dqm), .addr(addr),
        .bank(bank), .dq_in(dq_in)
    );

    assign cmd = {cs, ras, cas, we};

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word an ideal SDRAM returns for a given column.
    function automatic logic [15:0] word(input logic [7:0] c);
        return {c ^ 8'h5A, c};
    endfunction

    int cyc = 0;
    int act_cyc, rd_cyc, pre_cyc, ref_cyc, ack_cyc, first_ref;
    int n_cmd, n_ref, n_ack, vld_n, vld_first, vld_last, ref_space_bad, ref_gap_bad;
    logic [11:0] act_addr, rd_addr_o, pre_addr;
    logic [1:0]  act_bank;
    logic [7:0]  exp_col;
    int          drv_rd_cyc = -1000;
    logic [7:0]  drv_col = '0;

    task automatic clear_mon();
        act_cyc = -1; rd_cyc = -1; pre_cyc = -1; ref_cyc = -1; ack_cyc = -1; first_ref = -1;
        n_cmd = 0; n_ref = 0; n_ack = 0; vld_n = 0; vld_first = -1; vld_last = -1;
        ref_space_bad = 0; ref_gap_bad = 0;
        act_addr = '0; rd_addr_o = '0; pre_addr = '0; act_bank = '0;
    endtask

    // Advance one cycle, observe the pins, then play SDRAM and host for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cmd != NOP_CD) begin
            n_cmd++;
            if (ref_cyc >= 0 && cyc - ref_cyc <= TIME_TRC) ref_gap_bad++;
        end
        if (cmd == ACTIVE_CD) begin act_cyc = cyc; act_addr = addr; act_bank = bank; end
        if (cmd == READ_CD) begin
            rd_cyc = cyc; rd_addr_o = addr;
            drv_rd_cyc = cyc; drv_col = addr[7:0];
        end
        if (cmd == CHARGE_CD) begin pre_cyc = cyc; pre_addr = addr; end
        if (cmd == REF_CD) begin
            if (ref_cyc >= 0 && cyc - ref_cyc != TIME_REF) ref_space_bad++;
            if (first_ref < 0) first_ref = cyc;
            ref_cyc = cyc;
            n_ref++;
        end
        if (rd_ack) begin ack_cyc = cyc; n_ack++; end
        if (rd_data_vld) begin
            if (vld_first < 0) vld_first = cyc;
            vld_last = cyc;
            vld_n++;
            check("rd_data", {16'h0, rd_data}, {16'h0, word(exp_col)});
            exp_col++;
        end
        if (cyc - drv_rd_cyc >= CAS_LAT && cyc - drv_rd_cyc < CAS_LAT + BURST_LEN)
            dq_in = word(drv_col + 8'(cyc - drv_rd_cyc - CAS_LAT));
        else
            dq_in = 16'hDEAD;
        if (rd_ack) rd_req = 1'b0;
    endtask

    int e_cyc, t_cyc, p_cyc, t2_cyc, x_cyc, bad_cmd, bad_dqm, bad_ack;

    initial begin
        rst = 1'b1; init_done = 1'b0; rd_req = 1'b0; rd_addr = '0; dq_in = 16'hDEAD;
        clear_mon();
        exp_col = '0;

        // Reset values
        repeat (3) tick();
        check("rst_cmd", {28'h0, cmd}, {28'h0, NOP_CD});
        check("rst_dqm_cke", {29'h0, dqm, cke}, 32'h7);
        check("rst_ack_vld_busy", {29'h0, rd_ack, rd_data_vld, busy}, 32'h0);
        check("rst_addr_bank", {18'h0, addr, bank}, 32'h0);
        check("rst_data", {16'h0, rd_data}, 32'h0);

        // Pre-init: request held high must be ignored
        rst = 1'b0; rd_req = 1'b1; rd_addr = 22'h2A5C10;
        bad_cmd = 0; bad_dqm = 0; bad_ack = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cmd != NOP_CD) bad_cmd++;
            if (dqm != 2'b11) bad_dqm++;
            if (rd_ack) bad_ack++;
        end
        check("preinit_cmd", bad_cmd, 0);
        check("preinit_dqm", bad_dqm, 0);
        check("preinit_ack", bad_ack, 0);
        rd_req = 1'b0;

        // Single read
        init_done = 1'b1;
        e_cyc = cyc;
        tick();
        check("dqm_after_init", {30'h0, dqm}, 32'h0);
        tick();
        rd_req = 1'b1; rd_addr = 22'h2A5C10;
        t_cyc = cyc;
        clear_mon();
        exp_col = 8'h10;
        repeat (270) tick();
        check("rd1_act_cyc", act_cyc, t_cyc + 1);
        check("rd1_act_bank", {30'h0, act_bank}, 32'h2);
        check("rd1_act_addr", {20'h0, act_addr}, 32'hA5C);
        check("rd1_ack_cyc", ack_cyc, t_cyc + 1);
        check("rd1_ack_n", n_ack, 1);
        check("rd1_read_cyc", rd_cyc, t_cyc + 4);
        check("rd1_read_addr", {20'h0, rd_addr_o}, 32'h010);
        check("rd1_pre_cyc", pre_cyc, t_cyc + 260);
        check("rd1_pre_addr", {20'h0, pre_addr}, 32'h400);
        check("rd1_vld_n", vld_n, 256);
        check("rd1_vld_first", vld_first, t_cyc + 8);
        check("rd1_vld_last", vld_last, t_cyc + 263);
        check("rd1_cmd_n", n_cmd, 3);
        check("rd1_busy_end", {31'h0, busy}, 32'h0);

        // Refresh cadence while idle
        clear_mon();
        while (cyc < e_cyc + 5300) tick();
        check("cad_ref_n", n_ref, 3);
        check("cad_first_ref", first_ref, e_cyc + 1563);
        check("cad_spacing", ref_space_bad, 0);
        check("cad_nop_gap", ref_gap_bad, 0);
        check("cad_cmd_n", n_cmd, 3);

        // Read request in the same cycle the refresh becomes pending
        p_cyc = e_cyc + 4 * TIME_REF;
        while (cyc < p_cyc) tick();
        rd_req = 1'b1; rd_addr = 22'h1FFFFF;
        clear_mon();
        exp_col = 8'hFF;
        repeat (275) tick();
        check("col_ref_cyc", ref_cyc, p_cyc + 1);
        check("col_act_cyc", act_cyc, p_cyc + 9);
        check("col_ack_cyc", ack_cyc, p_cyc + 9);
        check("col_act_bank", {30'h0, act_bank}, 32'h1);
        check("col_act_addr", {20'h0, act_addr}, 32'hFFF);
        check("col_read_cyc", rd_cyc, p_cyc + 12);
        check("col_read_addr", {20'h0, rd_addr_o}, 32'h0FF);
        check("col_pre_cyc", pre_cyc, p_cyc + 268);
        check("col_vld_n", vld_n, 256);
        check("col_vld_first", vld_first, p_cyc + 16);
        check("col_vld_last", vld_last, p_cyc + 271);
        check("col_nop_gap", ref_gap_bad, 0);

        // Refresh expiry 100 cycles into RD, with a second read queued
        t2_cyc = p_cyc + TIME_REF - 104;
        while (cyc < t2_cyc) tick();
        rd_req = 1'b1; rd_addr = 22'h001280;
        clear_mon();
        exp_col = 8'h80;
        repeat (10) tick();
        rd_req = 1'b1; rd_addr = 22'h300000;
        while (cyc < t2_cyc + 266) tick();
        check("mid_act_cyc", act_cyc, t2_cyc + 1);
        check("mid_act_addr", {18'h0, act_addr, act_bank}, {18'h0, 12'h012, 2'd0});
        check("mid_read_cyc", rd_cyc, t2_cyc + 4);
        check("mid_read_addr", {20'h0, rd_addr_o}, 32'h080);
        check("mid_pre_cyc", pre_cyc, t2_cyc + 260);
        check("mid_vld_n", vld_n, 256);
        check("mid_vld_first", vld_first, t2_cyc + 8);
        check("mid_vld_last", vld_last, t2_cyc + 263);
        check("mid_ref_cyc", ref_cyc, t2_cyc + 264);
        check("mid_ack_n", n_ack, 1);
        clear_mon();
        exp_col = 8'h00;
        while (cyc < t2_cyc + 272) tick();
        check("q_act_cyc", act_cyc, t2_cyc + 272);
        check("q_ack_cyc", ack_cyc, t2_cyc + 272);
        check("q_act_addr", {18'h0, act_addr, act_bank}, {18'h0, 12'h000, 2'd3});

        // Reset 50 cycles into the valid window of the queued read
        x_cyc = t2_cyc + 271 + 58;
        while (cyc < x_cyc) tick();
        check("q_read_cyc", rd_cyc, t2_cyc + 275);
        rst = 1'b1; init_done = 1'b0; rd_req = 1'b0;
        tick();
        check("rstb_vld", {31'h0, rd_data_vld}, 32'h0);
        check("rstb_cmd", {28'h0, cmd}, {28'h0, NOP_CD});
        check("rstb_busy_data", {15'h0, busy, rd_data}, 32'h0);
        check("rstb_vld_n", vld_n, 51);
        check("rstb_vld_last", vld_last, x_cyc);
        clear_mon();
        tick();
        rst = 1'b0;
        repeat (300) tick();
        check("rstb_post_cmds", n_cmd, 0);
        check("rstb_post_vld", vld_n, 0);
        check("rstb_post_ack", n_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
